// File: rtl/proc_mem_pkg.sv
// Shared types and defaults for the proc memory responder.
// PROC_MEM_DLOAD_EN adds the S_DLOAD state (data memory preload after instruction load).
package proc_mem_pkg;

  localparam int unsigned c_IMEM_DEPTH = 256;
  localparam int unsigned c_DMEM_DEPTH = 256;

  typedef logic [15:0] TypeInstr;
  typedef logic [15:0] TypeInstrAddr;
  typedef logic [7:0]  TypeDataWord;
  typedef logic [7:0]  TypeDataAddr;

  typedef enum logic [1:0] {
    S_ILOAD = 2'd0,
`ifdef PROC_MEM_DLOAD_EN
    S_DLOAD = 2'd1,
`endif
    S_RUN   = 2'd2
  } TypeMemState;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } TypeBytePhase;

endpackage

// File: rtl/proc_mem_loader.sv
// Byte-serial program loader: fills imem (and dmem when PROC_MEM_DLOAD_EN is defined)
// after reset and holds the core in reset until the final byte is accepted.
module proc_mem_loader
  import proc_mem_pkg::*;
#(
  parameter int unsigned IAW = 8,
  parameter int unsigned DAW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_valid_i,
  input  logic [7:0]     load_data_i,
  input  logic           load_last_i,
  output logic           load_ready_o,
  output logic           proc_reset_o,
  output logic           run_o,
  output logic           imem_we_o,
  output logic [IAW-1:0] imem_addr_o,
  output logic [15:0]    imem_wdata_o,
  output logic           dmem_we_o,
  output logic [DAW-1:0] dmem_addr_o,
  output logic [7:0]     dmem_wdata_o
);

`ifdef PROC_MEM_DLOAD_EN
  localparam TypeMemState ILOAD_NEXT = S_DLOAD;
`else
  localparam TypeMemState ILOAD_NEXT = S_RUN;
`endif

  TypeMemState    state_q, state_d;
  TypeBytePhase   phase_q, phase_d;
  logic [IAW-1:0] ptr_q, ptr_d;
  logic [7:0]     hold_q, hold_d;
  logic           accept;

`ifdef PROC_MEM_DLOAD_EN
  logic [DAW-1:0] dptr_q, dptr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ILOAD;
      phase_q <= PH_HI;
      ptr_q   <= '0;
      hold_q  <= '0;
`ifdef PROC_MEM_DLOAD_EN
      dptr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
`ifdef PROC_MEM_DLOAD_EN
      dptr_q  <= dptr_d;
`endif
    end
  end

  // Decoded from registered state only, so the core reset never glitches.
  assign run_o        = (state_q == S_RUN);
  assign proc_reset_o = ~run_o;
  assign load_ready_o = ~run_o;
  assign accept       = load_valid_i & load_ready_o;
  assign imem_addr_o  = ptr_q;
  assign dmem_wdata_o = load_data_i;
`ifdef PROC_MEM_DLOAD_EN
  assign dmem_addr_o  = dptr_q;
`else
  assign dmem_addr_o  = '0;
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    imem_we_o    = 1'b0;
    imem_wdata_o = {hold_q, load_data_i};
    dmem_we_o    = 1'b0;
`ifdef PROC_MEM_DLOAD_EN
    dptr_d       = dptr_q;
`endif
    case (state_q)
      S_ILOAD: begin
        if (accept) begin
          if (phase_q == PH_HI) begin
            if (load_last_i) begin
              // A lone high byte still lands as a full word, low byte zeroed.
              imem_we_o    = 1'b1;
              imem_wdata_o = {load_data_i, 8'h00};
              state_d      = ILOAD_NEXT;
            end else begin
              hold_d  = load_data_i;
              phase_d = PH_LO;
            end
          end else begin
            imem_we_o = 1'b1;
            ptr_d     = ptr_q + 1'b1;
            phase_d   = PH_HI;
            if (load_last_i) begin
              state_d = ILOAD_NEXT;
            end
          end
        end
      end
`ifdef PROC_MEM_DLOAD_EN
      S_DLOAD: begin
        if (accept) begin
          dmem_we_o = 1'b1;
          dptr_d    = dptr_q + 1'b1;
          if (load_last_i) begin
            state_d = S_RUN;
          end
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_mem.sv
// Memory-side responder for the multicycle proc core: zero-latency imem/dmem reads,
// stores, saturating store counter, and the program loader (PROC_MEM_DLOAD_EN adds dmem preload).
module proc_mem
  import proc_mem_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = c_IMEM_DEPTH,
  parameter int unsigned DMEM_DEPTH = c_DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instrAddr,
  output logic [15:0] instrData,
  input  logic [7:0]  dataAddr,
  input  logic [7:0]  dataWrite,
  input  logic        writeEnable,
  output logic [7:0]  dataRead,
  input  logic        loadValid,
  input  logic [7:0]  loadData,
  input  logic        loadLast,
  output logic        loadReady,
  output logic        procReset,
  output logic [15:0] writeCount
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  TypeInstr    imem [IMEM_DEPTH];
  TypeDataWord dmem [DMEM_DEPTH];

  logic           run;
  logic           ld_imem_we;
  logic [IAW-1:0] ld_imem_addr;
  logic [15:0]    ld_imem_wdata;
  logic           ld_dmem_we;
  logic [DAW-1:0] ld_dmem_addr;
  logic [7:0]     ld_dmem_wdata;
  logic           store;
  logic [15:0]    write_count_q, write_count_d;

  proc_mem_loader #(
    .IAW (IAW),
    .DAW (DAW)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (loadValid),
    .load_data_i  (loadData),
    .load_last_i  (loadLast),
    .load_ready_o (loadReady),
    .proc_reset_o (procReset),
    .run_o        (run),
    .imem_we_o    (ld_imem_we),
    .imem_addr_o  (ld_imem_addr),
    .imem_wdata_o (ld_imem_wdata),
    .dmem_we_o    (ld_dmem_we),
    .dmem_addr_o  (ld_dmem_addr),
    .dmem_wdata_o (ld_dmem_wdata)
  );

  // proc samples read data in the same cycle it presents the address.
  assign instrData = imem[instrAddr[IAW:1]];
  assign dataRead  = dmem[dataAddr[DAW-1:0]];

  assign store = run & writeEnable;

  always_ff @(posedge clk) begin
    if (ld_imem_we) begin
      imem[ld_imem_addr] <= ld_imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      dmem[dataAddr[DAW-1:0]] <= dataWrite;
    end else if (ld_dmem_we) begin
      dmem[ld_dmem_addr] <= ld_dmem_wdata;
    end
  end

  always_comb begin
    write_count_d = write_count_q;
    if (store && (write_count_q != '1)) begin
      write_count_d = write_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_count_q <= '0;
    end else begin
      write_count_q <= write_count_d;
    end
  end

  assign writeCount = write_count_q;

  generate
    if (IAW + 1 < 16) begin : g_iaddr_unused
      logic unused_iaddr;
      assign unused_iaddr = ^{instrAddr[0], instrAddr[15:IAW+1]};
    end else begin : g_iaddr_bit0_unused
      logic unused_iaddr;
      assign unused_iaddr = instrAddr[0];
    end
    if (DAW < 8) begin : g_daddr_unused
      logic unused_daddr;
      assign unused_daddr = ^dataAddr[7:DAW];
    end
  endgenerate

endmodule

// File: tb/tb_proc_mem.sv
// Directed self-checking bench for proc_mem (loader, reads, stores, write counter).
module tb_proc_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instrAddr = '0;
  logic [15:0] instrData;
  logic [7:0]  dataAddr = '0;
  logic [7:0]  dataWrite = '0;
  logic        writeEnable = 1'b0;
  logic [7:0]  dataRead;
  logic        loadValid = 1'b0;
  logic [7:0]  loadData = '0;
  logic        loadLast = 1'b0;
  logic        loadReady;
  logic        procReset;
  logic [15:0] writeCount;

  int n_run  = 0;
  int n_fail = 0;

  proc_mem #(
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instrAddr   (instrAddr),
    .instrData   (instrData),
    .dataAddr    (dataAddr),
    .dataWrite   (dataWrite),
    .writeEnable (writeEnable),
    .dataRead    (dataRead),
    .loadValid   (loadValid),
    .loadData    (loadData),
    .loadLast    (loadLast),
    .loadReady   (loadReady),
    .procReset   (procReset),
    .writeCount  (writeCount)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    loadValid = 1'b0;
    loadLast = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    loadValid = 1'b1;
    loadData  = b;
    loadLast  = last;
    @(posedge clk);
    #1;
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++; if (procReset !== 1'b1) begin n_fail++; $display("FAIL reset_procReset got %b exp 1", procReset); end
    n_run++; if (loadReady !== 1'b1) begin n_fail++; $display("FAIL reset_loadReady got %b exp 1", loadReady); end
    n_run++; if (writeCount !== 16'h0000) begin n_fail++; $display("FAIL reset_writeCount got %h exp 0000", writeCount); end
  endtask

  task automatic test_iload();
    logic [15:0] addrs [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0003};
    logic [15:0] exps  [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'h5678};
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h9A, 1'b0);
    n_run++; if (procReset !== 1'b1) begin n_fail++; $display("FAIL iload_procReset_before_last got %b exp 1", procReset); end
    send_byte(8'hBC, 1'b1);
    n_run++; if (procReset !== 1'b0) begin n_fail++; $display("FAIL iload_procReset_after_last got %b exp 0", procReset); end
    n_run++; if (loadReady !== 1'b0) begin n_fail++; $display("FAIL iload_loadReady_run got %b exp 0", loadReady); end
    for (int i = 0; i < 4; i++) begin
      instrAddr = addrs[i];
      #1;
      n_run++;
      if (instrData !== exps[i]) begin
        n_fail++; $display("FAIL iload_read addr %h got %h exp %h", addrs[i], instrData, exps[i]);
      end
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    writeEnable = 1'b1; dataAddr = 8'd10; dataWrite = 8'h33;
    @(posedge clk); #1;
    writeEnable = 1'b0;
    @(negedge clk);
    writeEnable = 1'b1; dataWrite = 8'h5A;
    #1;
    n_run++; if (dataRead !== 8'h33) begin n_fail++; $display("FAIL store_old_value got %h exp 33", dataRead); end
    @(posedge clk); #1;
    writeEnable = 1'b0;
    n_run++; if (dataRead !== 8'h5A) begin n_fail++; $display("FAIL store_new_value got %h exp 5A", dataRead); end
    @(negedge clk);
    writeEnable = 1'b1; dataAddr = 8'd11; dataWrite = 8'hC3;
    @(posedge clk); #1;
    writeEnable = 1'b0;
    dataAddr = 8'd10;
    #1;
    n_run++; if (dataRead !== 8'h5A) begin n_fail++; $display("FAIL store_neighbour_intact got %h exp 5A", dataRead); end
    dataAddr = 8'd11;
    #1;
    n_run++; if (dataRead !== 8'hC3) begin n_fail++; $display("FAIL store_addr11 got %h exp C3", dataRead); end
    n_run++; if (writeCount !== 16'd3) begin n_fail++; $display("FAIL store_writeCount got %0d exp 3", writeCount); end
  endtask

  task automatic test_run_ignores_loader();
    logic [15:0] exps [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      loadValid = 1'b1; loadData = 8'hFF; loadLast = (i == 3);
      #1;
      n_run++; if (loadReady !== 1'b0) begin n_fail++; $display("FAIL run_loadReady cyc %0d got %b exp 0", i, loadReady); end
      @(posedge clk); #1;
      n_run++; if (procReset !== 1'b0) begin n_fail++; $display("FAIL run_procReset cyc %0d got %b exp 0", i, procReset); end
    end
    loadValid = 1'b0; loadLast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instrAddr = 16'(2 * i);
      #1;
      n_run++;
      if (instrData !== exps[i]) begin
        n_fail++; $display("FAIL run_imem_unchanged word %0d got %h exp %h", i, instrData, exps[i]);
      end
    end
  endtask

  task automatic test_hi_last();
    do_reset();
    @(negedge clk);
    writeEnable = 1'b1; dataAddr = 8'd10; dataWrite = 8'h99;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'hAB, 1'b1);
    writeEnable = 1'b0;
    n_run++; if (procReset !== 1'b0) begin n_fail++; $display("FAIL hilast_procReset got %b exp 0", procReset); end
    n_run++; if (writeCount !== 16'd0) begin n_fail++; $display("FAIL load_store_not_counted got %0d exp 0", writeCount); end
    dataAddr = 8'd10;
    #1;
    n_run++; if (dataRead !== 8'h5A) begin n_fail++; $display("FAIL load_store_ignored got %h exp 5A", dataRead); end
    instrAddr = 16'h0000; #1;
    n_run++; if (instrData !== 16'h1122) begin n_fail++; $display("FAIL hilast_w0 got %h exp 1122", instrData); end
    instrAddr = 16'h0002; #1;
    n_run++; if (instrData !== 16'hAB00) begin n_fail++; $display("FAIL hilast_w1 got %h exp AB00", instrData); end
    instrAddr = 16'h0004; #1;
    n_run++; if (instrData !== 16'h9ABC) begin n_fail++; $display("FAIL hilast_w2_kept got %h exp 9ABC", instrData); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    n_run++; if (procReset !== 1'b1) begin n_fail++; $display("FAIL midload_procReset got %b exp 1", procReset); end
    do_reset();
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b1);
    instrAddr = 16'h0000; #1;
    n_run++; if (instrData !== 16'h7788) begin n_fail++; $display("FAIL midload_w0 got %h exp 7788", instrData); end
    instrAddr = 16'h0002; #1;
    n_run++; if (instrData !== 16'hAB00) begin n_fail++; $display("FAIL midload_w1_retained got %h exp AB00", instrData); end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k), 1'b0);
      send_byte(~8'(k), 1'b0);
    end
    n_run++; if (procReset !== 1'b1) begin n_fail++; $display("FAIL wrap_still_loading got %b exp 1", procReset); end
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b1);
    instrAddr = 16'h0000; #1;
    n_run++; if (instrData !== 16'hCAFE) begin n_fail++; $display("FAIL wrap_w0 got %h exp CAFE", instrData); end
    instrAddr = 16'h01FE; #1;
    n_run++; if (instrData !== 16'hFF00) begin n_fail++; $display("FAIL wrap_w255 got %h exp FF00", instrData); end
    instrAddr = 16'h0202; #1;
    n_run++; if (instrData !== 16'h01FE) begin n_fail++; $display("FAIL wrap_addr_alias got %h exp 01FE", instrData); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    writeEnable = 1'b1; dataAddr = 8'd30; dataWrite = 8'h42;
    repeat (65534) @(posedge clk);
    #1;
    n_run++; if (writeCount !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe got %h exp FFFE", writeCount); end
    @(posedge clk); #1;
    n_run++; if (writeCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff got %h exp FFFF", writeCount); end
    repeat (3) @(posedge clk);
    #1;
    writeEnable = 1'b0;
    n_run++; if (writeCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp FFFF", writeCount); end
    n_run++; if (dataRead !== 8'h42) begin n_fail++; $display("FAIL sat_data got %h exp 42", dataRead); end
  endtask

`ifdef PROC_MEM_DLOAD_EN
  task automatic test_dload();
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b1);
    n_run++; if (procReset !== 1'b1) begin n_fail++; $display("FAIL dload_procReset_mid got %b exp 1", procReset); end
    send_byte(8'h0A, 1'b0);
    n_run++; if (procReset !== 1'b1) begin n_fail++; $display("FAIL dload_procReset_0A got %b exp 1", procReset); end
    send_byte(8'h0B, 1'b1);
    n_run++; if (procReset !== 1'b0) begin n_fail++; $display("FAIL dload_procReset_end got %b exp 0", procReset); end
    dataAddr = 8'd0; #1;
    n_run++; if (dataRead !== 8'h0A) begin n_fail++; $display("FAIL dload_d0 got %h exp 0A", dataRead); end
    dataAddr = 8'd1; #1;
    n_run++; if (dataRead !== 8'h0B) begin n_fail++; $display("FAIL dload_d1 got %h exp 0B", dataRead); end
  endtask
`endif

  initial begin
    test_reset();
    test_iload();
    test_store();
    test_run_ignores_loader();
    test_hi_last();
    test_reset_midload();
    test_ptr_wrap();
    test_saturation();
`ifdef PROC_MEM_DLOAD_EN
    test_dload();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
